// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed for a counter that can hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - borrow_in, combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first, start/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_ext;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             bit_d;
    logic             bit_br;
    logic             last_bit;

    full_subtractor u_cell (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (br),
        .diff       (bit_d),
        .borrow_out (bit_br)
    );

    // Partial result keeps only the upper WIDTH-1 bits; the new bit completes the word.
    assign res_ext  = {bit_d, res_sr};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= borrow_in;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_ext[WIDTH-1:1];
                    br     <= bit_br;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff       <= res_ext;
                        borrow_out <= bit_br;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // On the final shift the operand MSBs sit at bit 0 of the shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (state == ST_SHIFT && last_bit) begin
            overflow <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ bit_d);
        end
    end
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - borrow_in, one bit per clock, LSB first.
- Inverse arithmetic companion to the team's full-adder blocks; one full-subtractor cell plus a borrow flip-flop replaces a WIDTH-wide ripple chain.
- Used where area matters more than latency; start/done handshake lets a controller or bench sequence operations.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- borrow_in  input  1  initial borrow, captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result register.
- borrow_out  output  1  final borrow (1 means a < b + borrow_in, unsigned).

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift registers, bit counter and borrow flip-flop cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1 at edge N, load a, b and borrow_in into internal registers, clear counter, go to SHIFT. When start=0, stay in IDLE.
- SHIFT: one bit per edge, LSB first.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the result register from the MSB side; operand registers shift right; counter increments.
  - After WIDTH SHIFT edges (edge N+WIDTH), go to DONE. On that edge load diff from the completed result and borrow_out from br_next.
- DONE: done=1 for exactly one cycle, then go to IDLE on the next edge.
- busy=1 exactly while state=SHIFT, i.e. WIDTH cycles.
- Latency: done is high in the cycle following edge N+WIDTH. A new start is accepted no earlier than edge N+WIDTH+2 (back in IDLE).
- diff and borrow_out change only on the SHIFT->DONE edge or on reset. They hold their value through IDLE and through the next operation until it completes.
- start during SHIFT or DONE is ignored, with no queuing. Operand changes after acceptance are ignored.
- Reset asserted mid-operation: abort, return to reset values on that edge, no done pulse.
- Reset and start together: reset wins.
- Arithmetic is modulo 2^WIDTH. Wrap-around is flagged only by borrow_out.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit): the two's-complement signed overflow of a - b - borrow_in, computed as (a_msb ^ b_msb) & (a_msb ^ diff_msb).
  - Updated on the same edge as diff; reset value 0; held like diff.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - a counter-width helper constant (clog2 of WIDTH+1).
- One natural sub-module: full_subtractor. It is combinational, with ports a, b, borrow_in, diff, borrow_out, and is instantiated once as the serial bit cell.
- FSM, shift registers and output registers live in the top.

Test Plan:
- WIDTH=8; a=0x05, b=0x03, borrow_in=0, start pulse -> busy high 8 cycles; done 1 cycle; diff=0x02, borrow_out=0.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1. a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1. a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
- Start held high continuously with a=0x10, b=0x01 -> first result 0x0F. Operands changed to 0x20/0x02 during SHIFT do not affect it; the second op is accepted only after done, giving 0x1E. Done pulses are exactly WIDTH+2 cycles apart.
- rst asserted at SHIFT cycle 4 -> next edge busy=0, diff=0x00, borrow_out=0, no done pulse. A subsequent start with 0x09-0x04 -> 0x05.
- Exhaustive sweep with WIDTH=4: all a, b, borrow_in combinations; compare diff/borrow_out against a reference model of {borrow,diff} = a - b - borrow_in.
- SERIAL_SUBTRACTOR_OVERFLOW_EN defined: 0x80-0x01 -> diff=0x7F, overflow=1; 0x7F-0xFF -> diff=0x80, overflow=1; 0x05-0x03 -> overflow=0.
